// File: rtl/mcadd_pkg.sv
// Shared types and sizing helpers for the multi-cycle ripple adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide slices that make up one operand.
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-digit configuration still gets one bit.
    function automatic int calc_cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcadd_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
module mcadd_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             ci,
    output logic [DIGIT-1:0] s_d,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] cv;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        cv    = '0;
        cv[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            cv[i+1] = (a_d[i] & b_d[i]) | (a_d[i] & cv[i]) | (b_d[i] & cv[i]);
        end
        s_d   = a_d ^ b_d ^ cv[DIGIT-1:0];
        co    = cv[DIGIT];
        c_msb = cv[DIGIT-1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: WIDTH-bit sum computed DIGIT bits per cycle, LSB first.
// Latency: NDIG = WIDTH/DIGIT cycles from accepted start to the done pulse.
// Backpressure: start is only accepted in IDLE/DONE; ignored while busy. MCADD_SUB_EN adds the sub port.
module multicycle_adder
    import mcadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MCADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int               NDIG     = calc_ndig(WIDTH, DIGIT);
    localparam int               CNT_W    = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

    // Reject illegal geometry at elaboration time.
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("multicycle_adder: illegal WIDTH/DIGIT combination");
    end

    // Subtraction folds into addition: a + ~b + 1, with cin overridden.
    logic sub_sel;
`ifdef MCADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    // Select the current digit by shifting the captured operands; the
    // registers themselves stay untouched for the whole operation.
    logic [31:0]      shamt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_c_msb;

    assign shamt = 32'(cnt_q) * 32'(DIGIT);
    assign a_sh  = a_q >> shamt;
    assign b_sh  = b_q >> shamt;
    assign dig_a = a_sh[DIGIT-1:0];
    assign dig_b = b_sh[DIGIT-1:0];

    mcadd_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (dig_a),
        .b_d   (dig_b),
        .ci    (c_q),
        .s_d   (dig_s),
        .co    (dig_co),
        .c_msb (dig_c_msb)
    );

    // Next-state and datapath update: capture on start, one digit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub_sel ? ~b : b;
                    c_d     = sub_sel ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = (acc_q & ~(DIG_MASK << shamt)) | (WIDTH'(dig_s) << shamt);
                c_d   = dig_co;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Carry into and out of the MSB both live in the final slice.
                    sum_d   = acc_d;
                    carry_d = dig_co;
                    ovf_d   = dig_c_msb ^ dig_co;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder at WIDTH=8, DIGIT=2 (four digits).
// Latency: checks the four-cycle start-to-done timing.
// Backpressure: covers start ignored in RUN and back-to-back start in DONE.
module tb_multicycle_adder;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MCADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         prev_v;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[12];
    int   n_vec;

    multicycle_adder #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef MCADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run one operation starting from IDLE/DONE at #1 after a rising edge.
    // If poke >= 0, start is pulsed with different operands in that RUN cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input logic [W-1:0] es, input logic ec,
                          input logic ev, input int poke, input string tag);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tcin;
`ifdef MCADD_SUB_EN
        sub   = tsub;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " no done in run"}, 32'(done), 32'd0);
            check({tag, " sum held in run"}, 32'(sum), 32'(prev_s));
            if (i == poke) begin
                start = 1'b1;
                a     = ~ta;
                b     = 8'h01;
                cin   = ~tcin;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy low at done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carry"}, 32'(carry), 32'(ec));
        check({tag, " overflow"}, 32'(overflow), 32'(ev));
        prev_s = es;
        prev_c = ec;
        prev_v = ev;
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle not busy"}, 32'(busy), 32'd0);
        check({tag, " sum holds"}, 32'(sum), 32'(prev_s));
    endtask

    initial begin
        // a, b, cin, sub, expected sum, carry, overflow
        vecs[0] = '{8'h55, 8'h33, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[3] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
        n_vec   = 8;
`ifdef MCADD_SUB_EN
        vecs[8]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[9]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[10] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0};
        n_vec    = 11;
`endif

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
`ifdef MCADD_SUB_EN
        sub    = 1'b0;
`endif
        prev_s = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;

        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset carry", 32'(carry), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < n_vec; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].s, vecs[i].c, vecs[i].v, -1, $sformatf("vec%0d", i));
        end

        // Start pulsed mid-RUN with other operands must be ignored.
        run_op(8'h55, 8'h33, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1, 1, "poke");

        // Start held high through RUN and DONE: back-to-back acceptance.
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h55;
        b = 8'h33;
        for (int i = 0; i < NDIG; i++) begin
            check("b2b first busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first sum", 32'(sum), 32'h10);
        check("b2b first carry", 32'(carry), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b rebusy", 32'(busy), 32'd1);
        check("b2b no done", 32'(done), 32'd0);
        for (int i = 1; i < NDIG; i++) begin
            @(posedge clk);
            #1;
            check("b2b second busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second sum", 32'(sum), 32'h88);
        check("b2b second overflow", 32'(overflow), 32'd1);
        prev_s = 8'h88;
        @(posedge clk);
        #1;
        check("b2b idle", 32'(done), 32'd0);

        // Reset asserted during the second RUN cycle.
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h33;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset sum", 32'(sum), 32'd0);
        check("mid reset carry", 32'(carry), 32'd0);
        check("mid reset overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < NDIG; i++) begin
            @(posedge clk);
            #1;
            check("held reset no done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_s = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;
        for (int i = 0; i < NDIG + 1; i++) begin
            @(posedge clk);
            #1;
            check("post reset no done", 32'(done), 32'd0);
            check("post reset not busy", 32'(busy), 32'd0);
        end
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, -1, "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
